// File: rtl/apb_pkg.sv
// Shared types for the round-robin APB master.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

  localparam int APB_AW = 5;
  localparam int APB_DW = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_master_if.sv
// APB bus between the shared master and the memory slave.
interface apb_rr_master_if
  import apb_pkg::*;
#(
  parameter int AW = APB_AW,
  parameter int DW = APB_DW
);

  logic [AW-1:0] Paddr;
  logic          Pselx;
  logic          Penable;
  logic          Pwrite;
  logic [DW-1:0] Pwdata;
  logic          Pready;
  logic [DW-1:0] Prdata;
  logic          Pslverr;

  modport master (
    output Paddr, Pselx, Penable,
    output Pwrite, Pwdata,
    input  Pready, Prdata, Pslverr
  );

  modport slave (
    input  Paddr, Pselx, Penable,
    input  Pwrite, Pwdata,
    output Pready, Prdata, Pslverr
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first pending request at or after ptr.
module rr_arbiter
  import apb_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
      j = (j == IW'(NREQ - 1)) ? '0 : j + 1'b1;
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB master sharing one APB slave among NREQ requesters.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = APB_AW,
  parameter int DW      = APB_DW,
  parameter int TIMEOUT = 16
) (
  input  logic             Pclk,
  input  logic             Prst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic [DW-1:0]    rdata,
  output logic             err,
  apb_rr_master_if.master  apb
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  apb_state_t      state;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req(req),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(arb_idx),
    .any(arb_any)
  );

  always_ff @(posedge Pclk) begin
    if (Prst) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      gnt         <= '0;
      done        <= '0;
      err         <= 1'b0;
      rdata       <= '0;
      apb.Paddr   <= '0;
      apb.Pselx   <= 1'b0;
      apb.Penable <= 1'b0;
      apb.Pwrite  <= 1'b0;
      apb.Pwdata  <= '0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          // a done pulse this cycle makes it the cooldown slot
          if (done == '0 && arb_any) begin
            gnt        <= arb_gnt;
            apb.Pwrite <= req_write[arb_idx];
            apb.Paddr  <= req_addr[arb_idx*AW +: AW];
            apb.Pwdata <= req_wdata[arb_idx*DW +: DW];
            apb.Pselx  <= 1'b1;
            ptr        <= (arb_idx == IW'(NREQ - 1)) ?
                          '0 : arb_idx + 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          apb.Penable <= 1'b1;
          cnt         <= '0;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (apb.Pready) begin
            if (!apb.Pwrite) rdata <= apb.Prdata;
            err         <= apb.Pslverr;
            done        <= gnt;
            gnt         <= '0;
            apb.Pselx   <= 1'b0;
            apb.Penable <= 1'b0;
            state       <= IDLE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            err         <= 1'b1;
            done        <= gnt;
            gnt         <= '0;
            apb.Pselx   <= 1'b0;
            apb.Penable <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench: requesters + APB memory slave model, transaction-level checking.
module tb_apb_rr_master;
  import apb_pkg::*;

  localparam int NREQ    = 2;
  localparam int AW      = 5;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic Pclk = 1'b0;
  logic Prst;
  always #5 Pclk = ~Pclk;

  logic [NREQ-1:0]    req, req_write, gnt, done;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [DW-1:0]      rdata;
  logic               err;

  apb_rr_master_if #(.AW(AW), .DW(DW)) apb();

  apb_rr_master #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .Pclk(Pclk),
    .Prst(Prst),
    .req(req),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .gnt(gnt),
    .done(done),
    .rdata(rdata),
    .err(err),
    .apb(apb)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [DW-1:0]   mem [32];
  logic            cmd_wr [NREQ];
  logic [AW-1:0]   cmd_addr [NREQ];
  logic [DW-1:0]   cmd_wd [NREQ];
  int              raise_cyc [NREQ];
  int              done_at [NREQ];
  int              grant_log [$];
  int              m_ptr = 0;
  logic [DW-1:0]   m_rdata = '0;
  logic [NREQ-1:0] exp_done = '0;
  logic            exp_err = 1'b0;
  logic [NREQ-1:0] prev_gnt = '0;
  bit              prev_setup = 1'b0;
  bit              active = 1'b0;
  bit              act_err = 1'b0;
  int              act_idx = 0, acc_cnt = 0, act_wait = 0;
  int              cyc = 0, last_done_cyc = -100;
  int              force_wait = -1, force_err = -1, raise_pct = 0;

  task automatic new_cmd(input int i, input logic wr,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    cmd_wr[i] = wr;
    cmd_addr[i] = a;
    cmd_wd[i] = d;
    req_write[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req[i] = 1'b1;
    raise_cyc[i] = cyc;
  endtask

  task automatic slave_idle();
    apb.Pready = 1'b0;
    apb.Prdata = $urandom;
    apb.Pslverr = 1'($urandom);
  endtask

  task automatic tick();
    logic [NREQ-1:0] req_seen;
    int w;
    @(negedge Pclk);
    cyc++;
    req_seen = req;
    // completion
    check("done", done, exp_done);
    check("err", err, (exp_done != 0) ? exp_err : 1'b0);
    if (exp_done != 0) begin
      check("rdata", rdata, m_rdata);
      check("pen_cycles", acc_cnt,
            (act_wait >= TIMEOUT) ? TIMEOUT : act_wait + 1);
      active = 1'b0;
      last_done_cyc = cyc;
    end
    for (int i = 0; i < NREQ; i++)
      if (done[i]) begin
        done_at[i] = cyc;
        req[i] = 1'b0;
      end
    exp_done = '0;
    // bus invariants
    check("gnt_onehot", $onehot0(gnt), 1'b1);
    check("gnt_vs_sel", gnt != 0, apb.Pselx);
    if (prev_setup) check("access_follows", apb.Penable, 1'b1);
    // new grant
    if (gnt != 0 && prev_gnt == 0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        int j = (m_ptr + k) % NREQ;
        if (w < 0 && req_seen[j]) w = j;
      end
      if (w < 0) check("gnt_spurious", gnt, 0);
      else begin
        check("gnt", gnt, 1 << w);
        check("setup", {apb.Pselx, apb.Penable}, 2'b10);
        check("paddr", apb.Paddr, cmd_addr[w]);
        check("pwrite", apb.Pwrite, cmd_wr[w]);
        check("pwdata", apb.Pwdata, cmd_wd[w]);
        check("cooldown", (cyc - last_done_cyc) >= 2, 1'b1);
        m_ptr = (w + 1) % NREQ;
        active = 1'b1;
        act_idx = w;
        acc_cnt = 0;
        if (force_wait >= 0) act_wait = force_wait;
        else if ($urandom_range(15) == 0) act_wait = TIMEOUT + 5;
        else act_wait = $urandom_range(3);
        if (force_err >= 0) act_err = force_err[0];
        else act_err = ($urandom_range(7) == 0);
        grant_log.push_back(w);
        // command is latched; scramble the requester side
        req_addr[w*AW +: AW] = AW'($urandom);
        req_wdata[w*DW +: DW] = $urandom;
        req_write[w] = 1'($urandom);
      end
    end
    prev_gnt = gnt;
    prev_setup = apb.Pselx && !apb.Penable;
    // slave
    if (apb.Penable) begin
      if (!active) begin
        check("penable_idle", apb.Penable, 1'b0);
        slave_idle();
      end else begin
        check("access_sel", apb.Pselx, 1'b1);
        check("access_gnt", gnt, 1 << act_idx);
        check("hold_addr", apb.Paddr, cmd_addr[act_idx]);
        check("hold_wr", apb.Pwrite, cmd_wr[act_idx]);
        check("hold_wdata", apb.Pwdata, cmd_wd[act_idx]);
        if (acc_cnt == act_wait) begin
          apb.Pready = 1'b1;
          apb.Prdata = mem[cmd_addr[act_idx]];
          apb.Pslverr = act_err;
          exp_done = NREQ'(1 << act_idx);
          exp_err = act_err;
          if (!cmd_wr[act_idx]) m_rdata = mem[cmd_addr[act_idx]];
          else if (!act_err) mem[cmd_addr[act_idx]] = cmd_wd[act_idx];
        end else begin
          slave_idle();
          if (acc_cnt == TIMEOUT - 1) begin
            exp_done = NREQ'(1 << act_idx);
            exp_err = 1'b1;
          end
        end
        acc_cnt++;
      end
    end else slave_idle();
    // requesters
    for (int i = 0; i < NREQ; i++)
      if (!req[i] && !done[i] && raise_pct > 0 &&
          $urandom_range(99) < raise_pct)
        new_cmd(i, 1'($urandom), AW'($urandom), $urandom);
  endtask

  task automatic wait_done(input int i);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!done[i] && n < 200);
    check("wait_done", done[i], 1'b1);
  endtask

  task automatic wait_any();
    int n = 0;
    do begin
      tick();
      n++;
    end while (done == 0 && n < 200);
    check("wait_any", done != 0, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    raise_pct = 0;
    while ((req != 0 || active || done != 0) && n < 400) begin
      tick();
      n++;
    end
    check("drain", {req != 0, active}, 2'b00);
  endtask

  initial begin
    int first, other, n;
    req = '0;
    req_write = '0;
    req_addr = '0;
    req_wdata = '0;
    apb.Pready = 1'b0;
    apb.Prdata = '0;
    apb.Pslverr = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    Prst = 1'b1;
    repeat (2) @(negedge Pclk);
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_bus", {apb.Pselx, apb.Penable, apb.Pwrite}, 0);
    check("rst_paddr", apb.Paddr, 0);
    check("rst_pwdata", apb.Pwdata, 0);
    Prst = 1'b0;

    // single write, zero-wait slave
    force_wait = 0;
    force_err = 0;
    new_cmd(0, 1'b1, 5'h03, 32'hDEADBEEF);
    wait_done(0);
    check("t1_latency", done_at[0] - raise_cyc[0], 3);
    check("t1_err", err, 1'b0);
    drain();

    // read back by the other requester
    new_cmd(1, 1'b0, 5'h03, '0);
    wait_done(1);
    check("t2_rdata", rdata, 32'hDEADBEEF);
    check("t2_who", grant_log[$], 1);
    drain();

    // contention
    grant_log.delete();
    new_cmd(0, 1'b1, 5'h07, $urandom);
    new_cmd(1, 1'b0, 5'h03, '0);
    raise_pct = 100;
    n = 0;
    while (grant_log.size() < 4 && n < 100) begin
      tick();
      n++;
    end
    drain();
    check("t3_count", grant_log.size() >= 4, 1'b1);
    for (int k = 0; k < 4; k++)
      if (k < grant_log.size())
        check("t3_order", grant_log[k], k % 2);

    // wait states, then slave error
    force_wait = 3;
    new_cmd(0, 1'b0, 5'h07, '0);
    wait_done(0);
    check("t4_penable", acc_cnt, 4);
    check("t4_latency", done_at[0] - raise_cyc[0], 6);
    drain();
    force_wait = 0;
    force_err = 1;
    new_cmd(1, 1'b1, 5'h09, $urandom);
    wait_done(1);
    check("t4_slverr", err, 1'b1);
    drain();

    // timeout, then the other requester is served
    force_wait = TIMEOUT + 5;
    force_err = 0;
    new_cmd(0, 1'b0, 5'h01, '0);
    new_cmd(1, 1'b0, 5'h02, '0);
    wait_any();
    check("t5_err", err, 1'b1);
    check("t5_len", acc_cnt, TIMEOUT);
    first = grant_log[$];
    other = 1 - first;
    force_wait = 0;
    wait_done(other);
    check("t5_next", grant_log[$], other);
    drain();

    // reset mid-ACCESS
    force_wait = TIMEOUT + 5;
    new_cmd(0, 1'b0, 5'h04, '0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!apb.Penable && n < 20);
    check("t6_in_access", apb.Penable, 1'b1);
    tick();
    Prst = 1'b1;
    apb.Pready = 1'b0;
    @(negedge Pclk);
    cyc++;
    check("t6_sel", {apb.Pselx, apb.Penable}, 2'b00);
    check("t6_gnt", gnt, 0);
    check("t6_done", done, 0);
    check("t6_rdata", rdata, 0);
    Prst = 1'b0;
    req = '0;
    m_ptr = 0;
    m_rdata = '0;
    active = 1'b0;
    exp_done = '0;
    prev_gnt = '0;
    prev_setup = 1'b0;
    last_done_cyc = -100;
    tick();
    force_wait = 0;
    new_cmd(0, 1'b0, 5'h03, '0);
    new_cmd(1, 1'b0, 5'h05, '0);
    wait_any();
    check("t6_ptr", grant_log[$], 0);
    drain();

    // random traffic
    force_wait = -1;
    force_err = -1;
    raise_pct = 30;
    repeat (3000) tick();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
